// File: rtl/fmlbrg_line.sv
// fmlbrg_line: 16-bit Wishbone slave to FML master bridge with a single 4-word write-back line.
// Optional build macro FMLBRG_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module fmlbrg_line #(
  parameter int fml_depth = 26
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [fml_depth-1:1] wb_adr_i,
  input  logic [15:0]          wb_dat_i,
  output logic [15:0]          wb_dat_o,
  input  logic [1:0]           wb_sel_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  output logic                 wb_ack_o,
  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  output logic                 fml_we,
  input  logic                 fml_ack,
  output logic [1:0]           fml_sel,
  output logic [15:0]          fml_do,
  input  logic [15:0]          fml_di
`ifdef FMLBRG_STATS_EN
  ,
  output logic [15:0]          hit_cnt,
  output logic [15:0]          miss_cnt
`endif
);

  localparam int TW = fml_depth - 3;

  typedef enum logic [2:0] {IDLE, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA} state_t;

  state_t         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [15:0]    line_q [4];
  logic [15:0]    line_d [4];
  logic [TW-1:0]  tag_q, tag_d;
  logic [TW-1:0]  miss_tag_q, miss_tag_d;
  logic           valid_q, valid_d;
  logic           dirty_q, dirty_d;
  logic           ack_q, ack_d;
  logic [15:0]    dat_o_q, dat_o_d;
  logic           stb_q, stb_d;
  logic           we_q, we_d;
  logic [fml_depth-1:0] adr_q, adr_d;
  logic [1:0]     sel_q, sel_d;
  logic [15:0]    do_q, do_d;
`ifdef FMLBRG_STATS_EN
  logic [15:0]    hit_cnt_q, hit_cnt_d;
  logic [15:0]    miss_cnt_q, miss_cnt_d;
  logic           replay_q, replay_d;
`endif

  logic [TW-1:0]  wb_tag;
  logic [1:0]     idx;
  logic           req;
  logic           hit;
  logic [15:0]    wr_word;

  assign wb_tag = wb_adr_i[fml_depth-1:3];
  assign idx    = wb_adr_i[2:1];
  assign req    = wb_cyc_i & wb_stb_i & ~ack_q;
  assign hit    = valid_q && (tag_q == wb_tag);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    tag_d      = tag_q;
    miss_tag_d = miss_tag_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    ack_d      = 1'b0;
    dat_o_d    = dat_o_q;
    stb_d      = stb_q;
    we_d       = we_q;
    adr_d      = adr_q;
    sel_d      = sel_q;
    do_d       = do_q;
    wr_word    = line_q[idx];
    if (wb_sel_i[0]) wr_word[7:0]  = wb_dat_i[7:0];
    if (wb_sel_i[1]) wr_word[15:8] = wb_dat_i[15:8];
`ifdef FMLBRG_STATS_EN
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    replay_d   = replay_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef FMLBRG_STATS_EN
        replay_d = 1'b0;
`endif
        if (req) begin
          if (hit) begin
            ack_d = 1'b1;
            if (wb_we_i) begin
              line_d[idx] = wr_word;
              if (wb_sel_i != 2'b00) dirty_d = 1'b1;
            end else begin
              dat_o_d = line_q[idx];
            end
`ifdef FMLBRG_STATS_EN
            // The replay right after a fill was already counted as a miss.
            if (!replay_q && hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
`endif
          end else begin
            miss_tag_d = wb_tag;
            stb_d      = 1'b1;
            sel_d      = 2'b11;
            if (valid_q && dirty_q) begin
              state_d = WB_REQ;
              we_d    = 1'b1;
              adr_d   = {tag_q, 3'b000};
              do_d    = line_q[0];
            end else begin
              state_d = FILL_REQ;
              we_d    = 1'b0;
              adr_d   = {wb_tag, 3'b000};
            end
`ifdef FMLBRG_STATS_EN
            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
`endif
          end
        end
      end
      WB_REQ: begin
        if (fml_ack) begin
          state_d = WB_DATA;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = 2'd1;
          do_d    = line_q[1];
        end
      end
      WB_DATA: begin
        if (cnt_q == 2'd3) begin
          dirty_d = 1'b0;
          state_d = FILL_REQ;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          adr_d   = {miss_tag_q, 3'b000};
          do_d    = 16'h0000;
        end else begin
          cnt_d = cnt_q + 2'd1;
          do_d  = line_q[cnt_q + 2'd1];
        end
      end
      FILL_REQ: begin
        if (fml_ack) begin
          state_d = FILL_DATA;
          stb_d   = 1'b0;
          cnt_d   = 2'd0;
        end
      end
      FILL_DATA: begin
        line_d[cnt_q] = fml_di;
        cnt_d         = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          tag_d   = miss_tag_q;
          valid_d = 1'b1;
          sel_d   = 2'b00;
          state_d = IDLE;
`ifdef FMLBRG_STATS_EN
          replay_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      tag_q      <= '0;
      miss_tag_q <= '0;
      valid_q    <= 1'b0;
      dirty_q    <= 1'b0;
      ack_q      <= 1'b0;
      dat_o_q    <= 16'h0000;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      sel_q      <= 2'b00;
      do_q       <= 16'h0000;
`ifdef FMLBRG_STATS_EN
      hit_cnt_q  <= 16'h0000;
      miss_cnt_q <= 16'h0000;
      replay_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      miss_tag_q <= miss_tag_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      ack_q      <= ack_d;
      dat_o_q    <= dat_o_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      sel_q      <= sel_d;
      do_q       <= do_d;
`ifdef FMLBRG_STATS_EN
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      replay_q   <= replay_d;
`endif
    end
  end

  // Line data needs no reset: valid_q gates every use of it.
  always_ff @(posedge sys_clk) begin
    line_q <= line_d;
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_o_q;
  assign fml_stb  = stb_q;
  assign fml_we   = we_q;
  assign fml_adr  = adr_q;
  assign fml_sel  = sel_q;
  assign fml_do   = do_q;
`ifdef FMLBRG_STATS_EN
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_fmlbrg_line.sv
// Testbench for fmlbrg_line: vector table for hits/misses, hand sequences for dirty miss,
// stalled arbiter, mid-burst reset and (with FMLBRG_STATS_EN) the counters.
module tb_fmlbrg_line;
  localparam int FD = 26;

  localparam logic [15:0] A0 = 16'h1A00, A1 = 16'h2A11, A2 = 16'h3A22, A3 = 16'h4A33;
  localparam logic [15:0] B0 = 16'h5B00, B1 = 16'h6B11, B2 = 16'h7B22, B3 = 16'h8B33;
  localparam logic [15:0] C0 = 16'h9C00, C1 = 16'hAC11, C2 = 16'hBC22, C3 = 16'hCC33;
  localparam logic [15:0] D0 = 16'hDD00, D1 = 16'hED11, D2 = 16'hFD22, D3 = 16'h0D33;

  // clock / reset
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [FD-1:1] wb_adr_i = '0;
  logic [15:0]   wb_dat_i = '0;
  logic [15:0]   wb_dat_o;
  logic [1:0]    wb_sel_i = '0;
  logic          wb_cyc_i = 1'b0;
  logic          wb_stb_i = 1'b0;
  logic          wb_we_i  = 1'b0;
  logic          wb_ack_o;
  logic [FD-1:0] fml_adr;
  logic          fml_stb;
  logic          fml_we;
  logic          fml_ack = 1'b0;
  logic [1:0]    fml_sel;
  logic [15:0]   fml_do;
  logic [15:0]   fml_di = '0;
`ifdef FMLBRG_STATS_EN
  logic [15:0]   hit_cnt;
  logic [15:0]   miss_cnt;
`endif

  fmlbrg_line #(.fml_depth(FD)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_we(fml_we), .fml_ack(fml_ack),
    .fml_sel(fml_sel), .fml_do(fml_do), .fml_di(fml_di)
`ifdef FMLBRG_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // FML memory responder: fixed ack delay, captures write bursts, feeds read bursts
  logic [15:0]   rd_words [4];
  logic [15:0]   wr_cap [4];
  int            fml_wait = 0;
  int            wait_cnt = 0;
  int            ph_left = 0;
  logic          cur_we = 1'b0;
  logic          resp_reset = 1'b0;
  int            n_wr = 0;
  int            n_rd = 0;
  logic [FD-1:0] wr_adr_log = '0;
  logic [FD-1:0] rd_adr_log = '0;
  logic [FD-1:0] stall_adr = '0;
  logic          stall_we = 1'b0;

  initial begin
    forever begin
      tick();
      fml_ack = 1'b0;
      fml_di  = 16'h0000;
      if (resp_reset) begin
        ph_left  = 0;
        wait_cnt = 0;
      end else if (ph_left != 0) begin
        if (cur_we) wr_cap[4-ph_left] = fml_do;
        else fml_di = rd_words[4-ph_left];
        ph_left--;
      end else if (fml_stb) begin
        if (wait_cnt == 0) begin
          stall_adr = fml_adr;
          stall_we  = fml_we;
        end else begin
          chk("fml_req_stable", {fml_we, fml_adr}, {stall_we, stall_adr});
        end
        if (wait_cnt < fml_wait) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          fml_ack  = 1'b1;
          cur_we   = fml_we;
          chk("fml_sel_busy", fml_sel, 2'b11);
          if (fml_we) begin
            wr_adr_log = fml_adr;
            n_wr++;
            wr_cap[0] = fml_do;
            ph_left = 3;
          end else begin
            rd_adr_log = fml_adr;
            n_rd++;
            ph_left = 4;
          end
        end
      end
    end
  end

  // Wishbone driver: latency counted in cycles after the request is first sampled
  task automatic wb_xfer(input logic [FD-1:0] addr, input logic we, input logic [15:0] dat,
                         input logic [1:0] sel, output logic [15:0] rdat, output int lat);
    logic [FD-1:0] a;
    a = addr;
    wb_adr_i = a[FD-1:1];
    wb_we_i  = we;
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    lat  = -1;
    rdat = 16'h0000;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (wb_ack_o) begin
        lat  = n;
        rdat = wb_dat_o;
        break;
      end
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    tick();
    chk("ack_single_pulse", wb_ack_o, 1'b0);
  endtask

  typedef struct {
    logic [FD-1:0] addr;
    logic          we;
    logic [15:0]   dat;
    logic [1:0]    sel;
    logic          chk_dat;
    logic [15:0]   exp_dat;
    int            exp_lat;
    int            exp_bursts;
  } vec_t;

  vec_t        vecs [5];
  logic [15:0] rdat;
  int          lat;
  int          nb;
  int          exp_hits = 0;
  int          exp_miss = 0;
  logic        found;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    chk("reset_outputs", {1'b0, wb_ack_o, wb_dat_o, fml_stb, fml_we, fml_adr, fml_sel, fml_do}, 64'd0);
    sys_rst_n = 1'b1;
    tick();

    rd_words = '{A0, A1, A2, A3};
    vecs[0] = '{26'h000010, 1'b0, 16'h0000, 2'b00, 1'b1, A0,       7, 1};
    vecs[1] = '{26'h000012, 1'b0, 16'h0000, 2'b00, 1'b1, A1,       1, 0};
    vecs[2] = '{26'h000014, 1'b1, 16'hBEEF, 2'b10, 1'b0, 16'h0000, 1, 0};
    vecs[3] = '{26'h000014, 1'b0, 16'h0000, 2'b00, 1'b1, 16'hBE22, 1, 0};
    vecs[4] = '{26'h000016, 1'b0, 16'h0000, 2'b00, 1'b1, A3,       1, 0};
    for (int i = 0; i < 5; i++) begin
      nb = n_rd + n_wr;
      wb_xfer(vecs[i].addr, vecs[i].we, vecs[i].dat, vecs[i].sel, rdat, lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      if (vecs[i].chk_dat) chk($sformatf("vec%0d_data", i), rdat, vecs[i].exp_dat);
      chk($sformatf("vec%0d_bursts", i), n_rd + n_wr - nb, vecs[i].exp_bursts);
      if (vecs[i].exp_lat == 1) exp_hits++;
      else exp_miss++;
    end
    chk("fill1_adr", rd_adr_log, 26'h000010);
    chk("idle_sel_do", {fml_sel, fml_do, fml_stb}, 19'd0);

    // dirty miss: write-back of the old line then refill
    rd_words = '{B0, B1, B2, B3};
    nb = n_rd + n_wr;
    wb_xfer(26'h000100, 1'b0, 16'h0000, 2'b00, rdat, lat);
    exp_miss++;
    chk("dirty_latency", lat, 11);
    chk("dirty_data", rdat, B0);
    chk("dirty_bursts", n_rd + n_wr - nb, 2);
    chk("wb_adr", wr_adr_log, 26'h000010);
    chk("wb_word0", wr_cap[0], A0);
    chk("wb_word1", wr_cap[1], A1);
    chk("wb_word2", wr_cap[2], 16'hBE22);
    chk("wb_word3", wr_cap[3], A3);
    chk("fill2_adr", rd_adr_log, 26'h000100);

    // a write with no byte lanes must leave the line clean and unchanged
    nb = n_rd + n_wr;
    wb_xfer(26'h000102, 1'b1, 16'h1234, 2'b00, rdat, lat);
    exp_hits++;
    chk("sel0_latency", lat, 1);
    wb_xfer(26'h000102, 1'b0, 16'h0000, 2'b00, rdat, lat);
    exp_hits++;
    chk("sel0_data", rdat, B1);

    // stalled arbiter on a clean miss
    rd_words = '{C0, C1, C2, C3};
    fml_wait = 10;
    wb_xfer(26'h000200, 1'b0, 16'h0000, 2'b00, rdat, lat);
    exp_miss++;
    fml_wait = 0;
    chk("stall_latency", lat, 17);
    chk("stall_data", rdat, C0);
    chk("stall_clean_bursts", n_rd + n_wr - nb, 1);
    chk("fill3_adr", rd_adr_log, 26'h000200);

`ifdef FMLBRG_STATS_EN
    chk("hit_cnt", hit_cnt, exp_hits[15:0]);
    chk("miss_cnt", miss_cnt, exp_miss[15:0]);
`endif

    // reset in the middle of a read burst
    rd_words = '{D0, D1, D2, D3};
    wb_adr_i = 25'(26'h000300 >> 1);
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (ph_left == 2 && !cur_we) begin
        found = 1'b1;
        break;
      end
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    chk("reach_fill_data", found, 1'b1);
    sys_rst_n  = 1'b0;
    resp_reset = 1'b1;
    tick();
    chk("midburst_reset_outputs", {1'b0, wb_ack_o, wb_dat_o, fml_stb, fml_we, fml_adr, fml_sel, fml_do}, 64'd0);
    sys_rst_n = 1'b1;
    tick();
    resp_reset = 1'b0;
    nb = n_rd + n_wr;
    wb_xfer(26'h000300, 1'b0, 16'h0000, 2'b00, rdat, lat);
    chk("post_reset_miss_latency", lat, 7);
    chk("post_reset_data", rdat, D0);
    chk("post_reset_bursts", n_rd + n_wr - nb, 1);

`ifdef FMLBRG_STATS_EN
    chk("miss_cnt_after_reset", miss_cnt, 16'd1);
    dut.hit_cnt_q = 16'hFFFF;
    wb_xfer(26'h000302, 1'b0, 16'h0000, 2'b00, rdat, lat);
    chk("sat_data", rdat, D1);
    chk("hit_cnt_saturated", hit_cnt, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
